// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// default payload/control widths and control-bundle bit positions.
package pipe_pkg;

    localparam int DATA_W_DEF = 58;
    localparam int CTRL_W_DEF = 9;

    // Control bundle layout, MSB first: RegDst, jump, MemRead, MemWrite,
    // ALUSrc, ALUOp[1:0], MemtoReg, RegWrite.
    localparam int REGDST_BIT   = 8;
    localparam int JUMP_BIT     = 7;
    localparam int MEMREAD_BIT  = 6;
    localparam int MEMWRITE_BIT = 5;
    localparam int ALUSRC_BIT   = 4;
    localparam int ALUOP_HI_BIT = 3;
    localparam int ALUOP_LO_BIT = 2;
    localparam int MEMTOREG_BIT = 1;
    localparam int REGWRITE_BIT = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    function automatic logic [1:0] occupancy_of(stage_state_t s);
        logic [1:0] occ;
        case (s)
            ST_FULL: occ = 2'd1;
            ST_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry.
// Define PIPE_STAGE_SKID_EN for the two-entry (registered in_ready) variant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    stage_state_t      state;
    stage_state_t      state_next;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              accept;
    logic              pop;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
`endif

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = main_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) state_next = ST_FULL;
                end
                ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (accept && !pop)      state_next = ST_SKID;
                    else if (pop && !accept) state_next = ST_EMPTY;
`else
                    if (pop && !accept) state_next = ST_EMPTY;
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (pop) state_next = ST_FULL;
                end
`endif
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // in_ready is gated by reset so nothing is accepted while reset is held.
    always_comb begin
        out_valid = (state != ST_EMPTY);
        occupancy = occupancy_of(state);
        out_ctrl  = out_valid ? main_ctrl : '0;
`ifdef PIPE_STAGE_SKID_EN
        in_ready  = !reset && (state != ST_SKID);
`else
        in_ready  = !reset && (!out_valid || out_ready);
`endif
    end

    // Flushed entries keep stale data but their control bits become a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data <= '0;
            skid_ctrl <= '0;
`endif
        end else if (flush) begin
            main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_ctrl <= '0;
`endif
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (accept && pop) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end
`else
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, corner-case
// sequences and random traffic checked against a queue-based model.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [57:0] in_data;
    logic [8:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [57:0] out_data;
    logic [8:0]  out_ctrl;
    logic [1:0]  occupancy;

    int total;
    int bad;

    typedef struct {
        logic        iv;
        logic [57:0] d;
        logic [8:0]  c;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [57:0] ed;
        logic [8:0]  ec;
        logic [1:0]  eocc;
    } vec_t;

    vec_t vecs[9];

    typedef struct {
        logic [57:0] d;
        logic [8:0]  c;
    } entry_t;

    entry_t model_q[$];

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic iv, input logic [57:0] d, input logic [8:0] c,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic        iv, ordy, fl, acc, pp, want_ready;
        logic [57:0] d;
        logic [8:0]  c;

        total = 0;
        bad   = 0;

        vecs[0] = '{1'b1, 58'h0ABC, 9'h1FF, 1'b1, 1'b0, 1'b1, 58'h0ABC, 9'h1FF, 2'd1};
        vecs[1] = '{1'b1, 58'h0123, 9'h055, 1'b1, 1'b0, 1'b1, 58'h0123, 9'h055, 2'd1};
        vecs[2] = '{1'b0, 58'h0,    9'h000, 1'b1, 1'b0, 1'b0, 58'h0,    9'h000, 2'd0};
        vecs[3] = '{1'b0, 58'h0,    9'h000, 1'b0, 1'b0, 1'b0, 58'h0,    9'h000, 2'd0};
        vecs[4] = '{1'b1, 58'h0777, 9'h100, 1'b0, 1'b0, 1'b1, 58'h0777, 9'h100, 2'd1};
        vecs[5] = '{1'b0, 58'h0,    9'h000, 1'b0, 1'b0, 1'b1, 58'h0777, 9'h100, 2'd1};
        vecs[6] = '{1'b1, 58'h0888, 9'h0F0, 1'b1, 1'b1, 1'b0, 58'h0,    9'h000, 2'd0};
        vecs[7] = '{1'b1, 58'h0999, 9'h003, 1'b1, 1'b0, 1'b1, 58'h0999, 9'h003, 2'd1};
        vecs[8] = '{1'b0, 58'h0,    9'h000, 1'b1, 1'b0, 1'b0, 58'h0,    9'h000, 2'd0};

        // Reset state, with upstream/downstream both eager.
        reset = 1'b1;
        applyStimulus(1'b1, 58'h5A5, 9'h1FF, 1'b1, 1'b0);
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 58'h0, 9'h0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl);
            tick();
            checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            checkOutput($sformatf("vec%0d_out_ctrl", i),  64'(out_ctrl),  64'(vecs[i].ec));
            checkOutput($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
            if (vecs[i].ev)
                checkOutput($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].ed));
        end

        // Back-pressure: the stage holds at most CAPACITY entries in order.
        applyStimulus(1'b1, 58'h1, 9'h011, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 58'h2, 9'h022, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 58'h3, 9'h033, 1'b0, 1'b0);
        #1;
        checkOutput("bp_occupancy", 64'(occupancy), 64'(CAPACITY));
        checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
        checkOutput("bp_out_data",  64'(out_data),  64'h1);
        tick();
        checkOutput("bp_hold_data", 64'(out_data),  64'h1);
        checkOutput("bp_hold_occ",  64'(occupancy), 64'(CAPACITY));
        applyStimulus(1'b0, 58'h0, 9'h0, 1'b1, 1'b0);
        #1;
        checkOutput("bp_first_out", 64'(out_data), 64'h1);
        tick();
`ifdef PIPE_STAGE_SKID_EN
        checkOutput("bp_second_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_second_out",   64'(out_data),  64'h2);
        checkOutput("bp_second_ctrl",  64'(out_ctrl),  64'h022);
        tick();
`endif
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // Flush with the stage as full as it gets and an input offered.
        applyStimulus(1'b1, 58'h11, 9'h0AA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 58'h22, 9'h0BB, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 58'h33, 9'h0CC, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 58'h0, 9'h0, 1'b1, 1'b0);
        #1;
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_out_ctrl",  64'(out_ctrl),  64'd0);
        checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
        tick();
        checkOutput("flush_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges while holding an entry.
        applyStimulus(1'b1, 58'h55, 9'h1C3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 58'h0, 9'h0, 1'b0, 1'b0);
        checkOutput("async_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_out_ctrl",  64'(out_ctrl),  64'd0);
        checkOutput("async_occupancy", 64'(occupancy), 64'd0);
        checkOutput("async_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("async_post_ready", 64'(in_ready), 64'd1);
        tick();

        // Continuous streaming: one transfer per cycle, strictly in order.
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'b1, 58'(i), 9'(i), 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
            tick();
            checkOutput($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("stream%0d_data", i),  64'(out_data),  64'(i));
            checkOutput($sformatf("stream%0d_occ", i),   64'(occupancy), 64'd1);
        end
        applyStimulus(1'b0, 58'h0, 9'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_end_valid", 64'(out_valid), 64'd0);

        // Random traffic against a queue model of capacity CAPACITY.
        pulseReset();
        model_q.delete();
        for (int n = 0; n < 1500; n++) begin
            iv   = (($urandom % 10) < 7);
            ordy = (($urandom % 10) < 6);
            fl   = (($urandom % 16) == 0);
            d    = 58'({$urandom, $urandom});
            c    = 9'($urandom);
            applyStimulus(iv, d, c, ordy, fl);
            #1;
            if (CAPACITY == 2)
                want_ready = (model_q.size() < 2);
            else
                want_ready = (model_q.size() == 0) || ordy;
            checkOutput("rnd_in_ready",  64'(in_ready),  64'(want_ready));
            checkOutput("rnd_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            checkOutput("rnd_occupancy", 64'(occupancy), 64'(model_q.size()));
            if (model_q.size() > 0) begin
                checkOutput("rnd_out_data", 64'(out_data), 64'(model_q[0].d));
                checkOutput("rnd_out_ctrl", 64'(out_ctrl), 64'(model_q[0].c));
            end else begin
                checkOutput("rnd_bubble_ctrl", 64'(out_ctrl), 64'd0);
            end
            acc = iv && want_ready;
            pp  = (model_q.size() > 0) && ordy;
            @(posedge clk);
            if (fl) begin
                model_q.delete();
            end else begin
                if (pp)  void'(model_q.pop_front());
                if (acc) model_q.push_back('{d, c});
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 58, width of the payload (rs,rt,rd,shamt,funct,extended).
REQ-002 SHALL provide parameter CTRL_W, default 9, width of the control bundle (RegDst,jump,MemRead,MemWrite,ALUSrc,ALUOp[1:0],MemtoReg,RegWrite).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid entry.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-010 SHALL have port out_valid  output  1  stage presents a valid entry.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  DATA_W  held payload.
REQ-013 SHALL have port out_ctrl  output  CTRL_W  held control; forced zero (bubble) whenever out_valid=0.
REQ-014 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-015 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-016 SHALL implement states EMPTY (0 entries), FULL (main register), SKID (main plus skid register).
REQ-017 EMPTY: accept -> FULL, main<=in; otherwise stay.
REQ-018 FULL: accept & pop -> FULL, main<=in; accept & !pop -> SKID, skid<=in; pop & !accept -> EMPTY; neither -> stay.
REQ-019 SKID: pop -> FULL, main<=skid; otherwise stay; no accept is possible in SKID.
REQ-020 SHALL drive in_ready = (state != SKID) as a registered function of state; no combinational path from out_ready to in_ready.
REQ-021 SHALL drive out_valid = (state != EMPTY), with out_data/out_ctrl from main register.
REQ-022 SHALL hold out_data/out_ctrl stable while out_valid & !out_ready.
REQ-023 SHALL give latency of exactly one cycle from accept to out_valid when the stage was EMPTY.
REQ-024 SHALL sustain one transfer per cycle while out_ready stays high; order is strictly FIFO.
REQ-025 flush SHALL take priority over all transitions: next state EMPTY, main and skid control bits cleared to zero; an accept in the flush cycle completes the handshake but its entry is discarded.
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID.

Reset
REQ-027 While reset is asserted: state EMPTY, main and skid data and control zero, out_valid=0, out_ctrl=0, occupancy=0, in_ready=0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries immediately without waiting for a clock edge.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: two-entry behaviour per REQ-016..REQ-020.
REQ-031 Macro PIPE_STAGE_SKID_EN undefined: skid register and SKID state absent; in_ready = !out_valid | out_ready (combinational, 0 during reset); FULL with accept & !pop is unreachable; occupancy max 1; all other requirements unchanged.

Structure
REQ-032 SHALL place the state encoding, default DATA_W/CTRL_W, and control-bit index constants (REGWRITE_BIT etc.) in shared package pipe_pkg.
REQ-033 SHALL be a single module with no sub-module; the id_rr stage is one instance of it with default parameters.

Verification
REQ-034 Reset, then in_valid=1, in_data=0x0ABC, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0x0ABC, occupancy=1.
REQ-035 out_ready=0, push A=0x1 then B=0x2 -> occupancy=2, in_ready=0, out_data=0x1 stable; release out_ready -> 0x1 then 0x2 on consecutive cycles.
REQ-036 Continuous in_valid=1, out_ready=1, data 1..100 -> 100 outputs in order, no gaps after first, occupancy stays 1.
REQ-037 Stage in SKID, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; flushed input never appears.
REQ-038 Assert reset asynchronously between edges while FULL -> out_valid=0 and out_ctrl=0 before next clk edge; in_ready=1 first cycle after deassert.
REQ-039 Build without PIPE_STAGE_SKID_EN, out_ready=0 while FULL, in_valid=1 -> in_ready=0, occupancy never exceeds 1.
